hc595_chain_driver: RTL and testbench



---
 rtl/hc595_chain_driver.sv | 141 ++++++++++++++
 tb/tb_hc595_chain_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_chain_driver.sv
// Serial master for a daisy chain of 74HC595 shift registers: shifts a parallel word out
// MSB-first on ser/srclk, then pulses rclk to move it into the output latches.
module hc595_chain_driver #(
  parameter int unsigned CHAIN = 1,
  parameter int unsigned DIV   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*CHAIN-1:0] data,
  output logic               busy,
  output logic               done,
  output logic               ser,
  output logic               srclk,
  output logic               rclk
);

  localparam int unsigned N  = 8 * CHAIN;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [7:0]    PhLoad  = 8'(DIV - 1);
  localparam logic [BW-1:0] BitLoad = BW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLatchLo,
    StLatchHi,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    sreg_q;
  logic [BW-1:0]   bitcnt_q;
  logic [7:0]      phase_q;
  logic            busy_q;
  logic            done_q;
  logic            ser_q;
  logic            srclk_q;
  logic            rclk_q;
  logic            phase_end;

  assign phase_end = (phase_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ser_q    <= 1'b0;
      srclk_q  <= 1'b0;
      rclk_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            sreg_q   <= data;
            ser_q    <= data[N-1];
            bitcnt_q <= BitLoad;
            phase_q  <= PhLoad;
            busy_q   <= 1'b1;
            srclk_q  <= 1'b0;
            state_q  <= StShiftLo;
          end
        end

        StShiftLo: begin
          if (phase_end) begin
            phase_q <= PhLoad;
            srclk_q <= 1'b1;
            state_q <= StShiftHi;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        // ser is only updated together with the falling srclk, so it is stable at every rise.
        StShiftHi: begin
          if (phase_end) begin
            phase_q <= PhLoad;
            srclk_q <= 1'b0;
            if (bitcnt_q == '0) begin
              ser_q   <= 1'b0;
              state_q <= StLatchLo;
            end else begin
              sreg_q   <= {sreg_q[N-2:0], 1'b0};
              ser_q    <= sreg_q[N-2];
              bitcnt_q <= bitcnt_q - 1'b1;
              state_q  <= StShiftLo;
            end
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StLatchLo: begin
          if (phase_end) begin
            phase_q <= PhLoad;
            rclk_q  <= 1'b1;
            state_q <= StLatchHi;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        StLatchHi: begin
          if (phase_end) begin
            rclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            phase_q <= phase_q - 8'd1;
          end
        end

        // Start is deliberately not sampled here; a held start re-triggers from StIdle.
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ser   = ser_q;
  assign srclk = srclk_q;
  assign rclk  = rclk_q;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Scoreboard bench: three driver configurations feed behavioural 595 models; a monitor
// pops the expected latch value, busy length and done time on every done pulse.
module tb_hc595_chain_driver;

  typedef struct {
    int latch;
    int blen;
    int dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_w [3];
  logic [15:0] dat [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic        ser_w [3];
  logic        srclk_w [3];
  logic        rclk_w [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  localparam int NB [3] = '{8, 16, 8};
  localparam int DV [3] = '{2, 1, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hc595_chain_driver #(.CHAIN(1), .DIV(2)) u_a (
    .clk(clk), .rst(rst), .start(start_w[0]), .data(dat[0][7:0]), .busy(busy_w[0]),
    .done(done_w[0]), .ser(ser_w[0]), .srclk(srclk_w[0]), .rclk(rclk_w[0])
  );
  hc595_chain_driver #(.CHAIN(2), .DIV(1)) u_b (
    .clk(clk), .rst(rst), .start(start_w[1]), .data(dat[1]), .busy(busy_w[1]),
    .done(done_w[1]), .ser(ser_w[1]), .srclk(srclk_w[1]), .rclk(rclk_w[1])
  );
  hc595_chain_driver #(.CHAIN(1), .DIV(1)) u_c (
    .clk(clk), .rst(rst), .start(start_w[2]), .data(dat[2][7:0]), .busy(busy_w[2]),
    .done(done_w[2]), .ser(ser_w[2]), .srclk(srclk_w[2]), .rclk(rclk_w[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    if (i == 0) return q0.size();
    if (i == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic exp_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    if (i == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  // Behavioural 595 chain models plus per-transfer statistics, sampled on the falling edge.
  int          blen [3];
  int          rhi [3];
  int          rises [3];
  int          rrises [3];
  logic [15:0] sr [3];
  logic [15:0] latch [3];
  logic        psrclk [3];
  logic        prclk [3];
  logic        pser [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      blen[i] = 0; rhi[i] = 0; rises[i] = 0; rrises[i] = 0;
      sr[i] = '0; latch[i] = '0; psrclk[i] = 1'b0; prclk[i] = 1'b0; pser[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        blen[i] = 0; rhi[i] = 0; rises[i] = 0; rrises[i] = 0;
      end else begin
        if (srclk_w[i] && !psrclk[i]) begin
          rises[i]++;
          chk($sformatf("ser_stable_at_srclk_rise[%0d]", i), int'(ser_w[i]), int'(pser[i]));
          sr[i] = {sr[i][14:0], ser_w[i]};
        end
        if (rclk_w[i] && !prclk[i]) begin
          rrises[i]++;
          latch[i] = sr[i];
        end
        if (busy_w[i]) blen[i]++;
        if (rclk_w[i]) rhi[i]++;
        if (done_w[i]) begin
          if (qsize(i) == 0) begin
            chk($sformatf("unexpected_done[%0d]", i), 1, 0);
          end else begin
            exp_t e;
            e = qpop(i);
            chk($sformatf("latch[%0d]", i), int'(latch[i]) & ((1 << NB[i]) - 1), e.latch);
            chk($sformatf("busy_len[%0d]", i), blen[i], e.blen);
            chk($sformatf("srclk_rises[%0d]", i), rises[i], NB[i]);
            chk($sformatf("rclk_rises[%0d]", i), rrises[i], 1);
            chk($sformatf("rclk_width[%0d]", i), rhi[i], DV[i]);
            chk($sformatf("busy_during_done[%0d]", i), int'(busy_w[i]), 0);
            if (e.dcyc >= 0) chk($sformatf("done_cycle[%0d]", i), cyc, e.dcyc);
          end
          blen[i] = 0; rhi[i] = 0; rises[i] = 0; rrises[i] = 0;
        end
      end
      psrclk[i] = srclk_w[i];
      prclk[i]  = rclk_w[i];
      pser[i]   = ser_w[i];
    end
  end

  task automatic push(input int i, input int l, input int b, input int d);
    exp_t e;
    e.latch = l; e.blen = b; e.dcyc = d;
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // Pulse start for one cycle; expected done lands busy-length cycles after the accepting edge.
  task automatic send(input int i, input logic [15:0] d, input int b);
    @(negedge clk);
    dat[i] = d;
    start_w[i] = 1'b1;
    push(i, int'(d), b, cyc + 1 + b);
    @(negedge clk);
    start_w[i] = 1'b0;
    dat[i] = ~d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("timeout_waiting_done", 1, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string name);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s[%0d]", name, i),
          int'({busy_w[i], done_w[i], ser_w[i], srclk_w[i], rclk_w[i]}), 0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 3; i++) begin
      start_w[i] = 1'b0;
      dat[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_outputs");
    rst = 1'b0;

    send(0, 16'h00A5, 36);
    wait_idle();
    send(1, 16'h1234, 34);
    wait_idle();
    chk("far_595", int'(latch[1][15:8]), 8'h12);
    chk("near_595", int'(latch[1][7:0]), 8'h34);
    send(2, 16'h0096, 18);
    wait_idle();

    // 0xFF request during busy must be dropped.
    send(0, 16'h0000, 36);
    repeat (3) @(negedge clk);
    dat[0] = 16'h00FF;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_idle();

    // Abort during the fourth SHIFT_HI; latch must keep 0x00.
    @(negedge clk);
    dat[0] = 16'h00A5;
    start_w[0] = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    start_w[0] = 1'b0;
    while (cyc < a + 14) @(negedge clk);
    chk("in_4th_shift_hi", int'(srclk_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort_outputs");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("latch_after_abort", int'(latch[0][7:0]), 8'h00);
    chk("busy_after_abort", int'(busy_w[0]), 0);
    send(0, 16'h003C, 36);
    wait_idle();

    // Held start re-triggers every 38 cycles.
    @(negedge clk);
    dat[0] = 16'h0081;
    start_w[0] = 1'b1;
    a = cyc + 1;
    push(0, 8'h81, 36, a + 36);
    push(0, 8'h81, 36, a + 74);
    push(0, 8'h81, 36, a + 112);
    repeat (100) @(negedge clk);
    start_w[0] = 1'b0;
    wait_idle();
    chk_idle_outputs("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
